// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: sequencer state encoding and default MISR constants,
// common to the memory signature reader and the LBIST pattern generator.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lbist_state_t;

  localparam logic [7:0] DEFAULT_POLY = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hFF;

endpackage

// File: rtl/mem_sig_reader_if.sv
// Read port between mem_sig_reader (master) and the mem array (slave).
interface mem_sig_reader_if #(
  parameter int word_size    = 8,
  parameter int address_bits = 4
);

  logic                    mem_en;
  logic                    mem_rw;
  logic [address_bits-1:0] mem_add;
  logic [word_size-1:0]    mem_data;

  modport master (
    output mem_en,
    output mem_rw,
    output mem_add,
    input  mem_data
  );

  modport slave (
    input  mem_en,
    input  mem_rw,
    input  mem_add,
    output mem_data
  );

endinterface

// File: rtl/mem_sig_reader_misr.sv
// Multiple-input signature register: shift left, fold POLY on MSB carry-out, xor data.
module misr #(
  parameter int               width = 8,
  parameter logic [width-1:0] POLY  = width'(8'hB8),
  parameter logic [width-1:0] SEED  = {width{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [width-1:0] data,
  output logic [width-1:0] signature
);

  logic [width-1:0] sig_next;

  always_comb begin
    sig_next = {signature[width-2:0], 1'b0} ^ (signature[width-1] ? POLY : '0) ^ data;
  end

  // load wins over en so a new sweep always starts from SEED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= SEED;
    end else if (load) begin
      signature <= SEED;
    end else if (en) begin
      signature <= sig_next;
    end
  end

endmodule

// File: rtl/mem_sig_reader.sv
// Sweeps every mem address in read mode and compacts the returned words into a MISR.
// Optional golden comparator built when MEM_SIG_GOLDEN_CMP_EN is defined.
module mem_sig_reader
  import lbist_pkg::*;
#(
  parameter int                   word_size    = 8,
  parameter int                   address_bits = 4,
  parameter logic [word_size-1:0] POLY         = word_size'(DEFAULT_POLY),
  parameter logic [word_size-1:0] SEED         = {word_size{1'b1}},
  parameter logic [word_size-1:0] GOLDEN       = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [word_size-1:0] signature,
  output lbist_state_t         state_dbg,
  mem_sig_reader_if.master     mem
);

  // Handshake: start is accepted only in IDLE (busy=0); busy stays high from the
  // accepting edge until the one-cycle done pulse falls. No backpressure exists.

  lbist_state_t            state, state_next;
  logic [address_bits-1:0] addr;
  // valid_pipe[0]: address driven this cycle; valid_pipe[1]: its data is on mem_data
  logic [1:0]              valid_pipe;
  logic                    accept;
  logic                    last_addr;

  assign accept    = (state == IDLE) && start;
  assign last_addr = &addr;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: if (last_addr) state_next = DRAIN;
      DRAIN: if (valid_pipe == 2'b10) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      valid_pipe <= '0;
    end else begin
      state         <= state_next;
      valid_pipe[1] <= valid_pipe[0];
      if (accept) begin
        addr          <= '0;
        valid_pipe[0] <= 1'b1;
      end else if (state == ISSUE) begin
        // stop at all-ones so the sweep never wraps into a second pass
        if (last_addr) begin
          valid_pipe[0] <= 1'b0;
        end else begin
          addr <= addr + address_bits'(1);
        end
      end
    end
  end

  misr #(
    .width (word_size),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .en        (valid_pipe[1]),
    .data      (mem.mem_data),
    .signature (signature)
  );

`ifdef MEM_SIG_GOLDEN_CMP_EN
  logic pass_q;

  // the final signature is stable throughout DONE, so compare it there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else if (accept) begin
      pass_q <= 1'b0;
    end else if (state == DONE) begin
      pass_q <= (signature == GOLDEN);
    end
  end

  assign pass = pass_q;
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign pass          = 1'b0;
`endif

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign state_dbg   = state;
  assign mem.mem_en  = valid_pipe[0];
  assign mem.mem_rw  = 1'b0;
  assign mem.mem_add = addr;

endmodule
